// File: rtl/bcd_entry_two_digit_if.sv
// bcd_entry_two_digit_if: raw active-low keys in, edited/committed BCD value out
interface bcd_entry_two_digit_if;
    logic       key_up_n;
    logic       key_down_n;
    logic       key_sel_n;
    logic       key_commit_n;
    logic [7:0] edit;
    logic [7:0] committed;
    logic       digit_sel;
    logic       commit_pulse;
    modport master (
        output key_up_n, key_down_n, key_sel_n, key_commit_n,
        input  edit, committed, digit_sel, commit_pulse
    );
    modport slave (
        input  key_up_n, key_down_n, key_sel_n, key_commit_n,
        output edit, committed, digit_sel, commit_pulse
    );
endinterface

// File: rtl/bcd_entry_two_digit.sv
// bcd_entry_two_digit: debounced four-key editor for a two-digit BCD value with hold-to-repeat
module bcd_entry_two_digit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_entry_two_digit_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    // key bit order: 0 up, 1 down, 2 sel, 3 commit
    logic [3:0]         raw, s1, s2, acc, acc_d, press;
    logic [3:0][DW-1:0] cnt;
    state_t             state, state_nxt;
    logic [31:0]        timer, timer_nxt;
    logic               dir, dir_nxt, step, cancel;
    logic [3:0]         cur, nxt;
    logic [7:0]         edit, committed;
    logic               digit_sel, commit_pulse;
    assign raw = {bus.key_commit_n, bus.key_sel_n, bus.key_down_n, bus.key_up_n};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '1;
            s2    <= '1;
            acc   <= '1;
            acc_d <= '1;
            press <= '0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            acc_d <= acc;
            press <= acc_d & ~acc;
            for (int i = 0; i < 4; i++)
                if (s2[i] == acc[i]) cnt[i] <= '0;
                else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end
    end
    // a repeat stops when its own key lets go or the opposite key goes down
    assign cancel = dir ? (acc[1] | ~acc[0]) : (acc[0] | ~acc[1]);
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        timer_nxt = timer == 32'd0 ? timer : timer - 32'd1;
        step      = 1'b0;
        if (state == IDLE) begin
            if (press[0] ^ press[1]) begin
                step      = 1'b1;
                dir_nxt   = press[1];
                timer_nxt = 32'(REPEAT_DELAY);
                state_nxt = HOLD;
            end
        end else if (cancel) state_nxt = IDLE;
        else if (timer == 32'd1) begin
            step      = 1'b1;
            timer_nxt = 32'(REPEAT_RATE);
            state_nxt = REPEAT;
        end
    end
    assign cur = digit_sel ? edit[7:4] : edit[3:0];
    assign nxt = dir_nxt ? (cur == 4'd0 ? 4'd9 : cur - 4'd1) : (cur == 4'd9 ? 4'd0 : cur + 4'd1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            dir          <= 1'b0;
            edit         <= '0;
            committed    <= '0;
            digit_sel    <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            dir          <= dir_nxt;
            commit_pulse <= press[3];
            if (step) edit <= digit_sel ? {nxt, edit[3:0]} : {edit[7:4], nxt};
            if (press[2]) digit_sel <= ~digit_sel;
            if (press[3]) committed <= edit;
        end
    end
    assign bus.edit         = edit;
    assign bus.committed    = committed;
    assign bus.digit_sel    = digit_sel;
    assign bus.commit_pulse = commit_pulse;
endmodule

// File: tb/tb_bcd_entry_two_digit.sv
// tb_bcd_entry_two_digit: vector table for key presses plus directed repeat/reset sequences
module tb_bcd_entry_two_digit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_app = 0;
    int   n_err = 0;
    bcd_entry_two_digit_if bus ();
    bcd_entry_two_digit #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    // keys: {commit, sel, down, up}, 1 = pressed; lat = edges after first low sample, -1 = no change
    typedef struct {
        logic [3:0] keys;
        logic [7:0] edit;
        logic [7:0] committed;
        logic       sel;
        int         pulses;
        int         lat;
    } vec_t;
    vec_t tv[22];
    task automatic chk(input string name, input int act, input int exp);
        n_app++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic set_keys(input logic [3:0] k);
        bus.key_up_n     = ~k[0];
        bus.key_down_n   = ~k[1];
        bus.key_sel_n    = ~k[2];
        bus.key_commit_n = ~k[3];
    endtask
    task automatic apply(input int idx);
        logic [7:0] pe, pc;
        logic       ps;
        int         lat, pulses;
        pe = bus.edit;
        pc = bus.committed;
        ps = bus.digit_sel;
        lat = -1;
        pulses = 0;
        set_keys(tv[idx].keys);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (bus.edit != pe || bus.committed != pc || bus.digit_sel != ps)) lat = c - 1;
            if (bus.commit_pulse) pulses++;
            if (c == 10) set_keys(4'b0000);
        end
        chk($sformatf("v%0d_edit", idx), int'(bus.edit), int'(tv[idx].edit));
        chk($sformatf("v%0d_committed", idx), int'(bus.committed), int'(tv[idx].committed));
        chk($sformatf("v%0d_digit_sel", idx), int'(bus.digit_sel), int'(tv[idx].sel));
        chk($sformatf("v%0d_pulses", idx), pulses, tv[idx].pulses);
        chk($sformatf("v%0d_latency", idx), lat, tv[idx].lat);
    endtask
    initial begin
        int n, c;
        int steps[$];
        int exp_off[4];
        logic [7:0] pe;
        exp_off = '{20, 25, 30, 35};
        for (int i = 0; i < 10; i++) tv[i] = '{4'b0001, 8'((i + 1) % 10), 8'h00, 1'b0, 0, 7};
        tv[10] = '{4'b0100, 8'h00, 8'h00, 1'b1, 0, 7};
        tv[11] = '{4'b0010, 8'h90, 8'h00, 1'b1, 0, 7};
        tv[12] = '{4'b1000, 8'h90, 8'h90, 1'b1, 1, 7};
        tv[13] = '{4'b0011, 8'h90, 8'h90, 1'b1, 0, -1};
        tv[14] = '{4'b0001, 8'h00, 8'h90, 1'b1, 0, 7};
        tv[15] = '{4'b0001, 8'h10, 8'h90, 1'b1, 0, 7};
        tv[16] = '{4'b0001, 8'h20, 8'h90, 1'b1, 0, 7};
        tv[17] = '{4'b0101, 8'h30, 8'h90, 1'b0, 0, 7};
        tv[18] = '{4'b0010, 8'h39, 8'h90, 1'b0, 0, 7};
        tv[19] = '{4'b0010, 8'h38, 8'h90, 1'b0, 0, 7};
        tv[20] = '{4'b0010, 8'h37, 8'h90, 1'b0, 0, 7};
        tv[21] = '{4'b1001, 8'h38, 8'h37, 1'b0, 1, 7};
        set_keys(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_edit", int'(bus.edit), 0);
        chk("rst_committed", int'(bus.committed), 0);
        chk("rst_digit_sel", int'(bus.digit_sel), 0);
        chk("rst_commit_pulse", int'(bus.commit_pulse), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_keys(4'b0001);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) set_keys(4'b0000);
            if (bus.edit != 8'h00 || bus.commit_pulse) n++;
        end
        chk("glitch_changes", n, 0);
        chk("glitch_edit", int'(bus.edit), 0);
        for (int i = 0; i < 22; i++) apply(i);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_keys(4'b0001);
        c = 0;
        while (bus.edit == 8'h00 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("rpt_first_step", int'(bus.edit), 8'h01);
        pe = bus.edit;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.edit != pe) begin
                steps.push_back(k);
                pe = bus.edit;
            end
            if (k == 33) set_keys(4'b0000);
        end
        chk("rpt_step_count", steps.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < steps.size()) chk($sformatf("rpt_offset%0d", i), steps[i], exp_off[i]);
        chk("rpt_final_edit", int'(bus.edit), 8'h05);
        set_keys(4'b0001);
        c = 0;
        pe = bus.edit;
        while (bus.edit == pe && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (22) @(posedge clk);
        #1;
        chk("midrpt_edit_before_reset", int'(bus.edit), 8'h07);
        rst_n = 1'b0;
        #1;
        chk("midrpt_rst_edit", int'(bus.edit), 0);
        chk("midrpt_rst_digit_sel", int'(bus.digit_sel), 0);
        chk("midrpt_rst_committed", int'(bus.committed), 0);
        chk("midrpt_rst_commit_pulse", int'(bus.commit_pulse), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c = 0;
        while (bus.edit == 8'h00 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("redebounce_latency", c - 1, 7);
        chk("redebounce_edit", int'(bus.edit), 8'h01);
        set_keys(4'b0000);
        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
        $finish;
    end
endmodule
